// File: rtl/tpx3_stream_marker.sv
// Small FWFT buffer between the readout arbiter and the BRAM FIFO that interleaves
// sequence-numbered heartbeat marker words into the data stream.
module tpx3_stream_marker #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [3:0]  IDENTIFIER = 4'b0110
) (
   input  logic        BUS_CLK,
   input  logic        BUS_RST,
   input  logic        IN_VALID,
   input  logic [31:0] IN_DATA,
   output logic        IN_READY,
   input  logic        FIFO_READ,
   output logic        FIFO_EMPTY,
   output logic [31:0] FIFO_DATA,
   input  logic [15:0] HB_PERIOD,
   input  logic        CLEAR,
   output logic        HB_OVERRUN,
   output logic [31:0] WORD_CNT
);

   localparam int unsigned    AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   // Reset asserts immediately but releases only after two clean clock edges.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
      if (!BUS_RST) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   hb_cnt_q, hb_cnt_d;
   logic [27:0]   seq_q, seq_d;
   logic          pending_q, pending_d;
   logic          overrun_q, overrun_d;
   logic [31:0]   word_cnt_q, word_cnt_d;

   logic          full;
   logic          empty;
   logic          pop;
   logic          mark_wr;
   logic          data_wr;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic          expiry;
   logic [15:0]   hb_last;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign pop     = FIFO_READ && !empty;
   // A pending marker always wins the write slot; data waits via IN_READY.
   assign mark_wr = pending_q && !full;
   assign data_wr = IN_VALID && IN_READY;
   assign wr_en   = mark_wr || data_wr;
   assign wr_data = mark_wr ? {IDENTIFIER, seq_q} : IN_DATA;

   assign hb_last = HB_PERIOD - 16'd1;
   // >= lets a shortened period take effect at the next compare instead of
   // running the counter all the way around.
   assign expiry  = (HB_PERIOD != 16'd0) && (hb_cnt_q >= hb_last);

   assign IN_READY   = !full && !pending_q;
   assign FIFO_EMPTY = empty;
   assign FIFO_DATA  = mem_q[rd_ptr_q];
   assign HB_OVERRUN = overrun_q;
   assign WORD_CNT   = word_cnt_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      hb_cnt_d   = hb_cnt_q;
      seq_d      = seq_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;
      word_cnt_d = word_cnt_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!wr_en && pop) begin
         count_d = count_q - (AW+1)'(1);
      end

      if (HB_PERIOD == 16'd0) begin
         hb_cnt_d = 16'd0;
      end else if (expiry) begin
         hb_cnt_d = 16'd0;
      end else begin
         hb_cnt_d = hb_cnt_q + 16'd1;
      end

      if (mark_wr) begin
         seq_d     = seq_q + 28'd1;
         pending_d = 1'b0;
      end
      if (expiry) begin
         pending_d = 1'b1;
         if (pending_q && !mark_wr) begin
            overrun_d = 1'b1;
         end
      end

      if (data_wr) begin
         word_cnt_d = word_cnt_q + 32'd1;
      end
      if (CLEAR) begin
         word_cnt_d = 32'd0;
         overrun_d  = 1'b0;
      end
   end

   always_ff @(posedge BUS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         hb_cnt_q   <= 16'd0;
         seq_q      <= 28'd0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
         word_cnt_q <= 32'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         hb_cnt_q   <= hb_cnt_d;
         seq_q      <= seq_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once count is zero.
   always_ff @(posedge BUS_CLK) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_tpx3_stream_marker.sv
// Directed bench for tpx3_stream_marker: expected words are queued as they are
// issued and a monitor pops them against every word the DUT hands out.
module tb_tpx3_stream_marker;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST = 1'b0;
   logic        IN_VALID = 1'b0;
   logic [31:0] IN_DATA = 32'd0;
   logic        IN_READY;
   logic        FIFO_READ = 1'b0;
   logic        FIFO_EMPTY;
   logic [31:0] FIFO_DATA;
   logic [15:0] HB_PERIOD = 16'd0;
   logic        CLEAR = 1'b0;
   logic        HB_OVERRUN;
   logic [31:0] WORD_CNT;

   tpx3_stream_marker #(.DEPTH(4), .IDENTIFIER(4'b0110)) dut (
      .BUS_CLK    (BUS_CLK),
      .BUS_RST    (BUS_RST),
      .IN_VALID   (IN_VALID),
      .IN_DATA    (IN_DATA),
      .IN_READY   (IN_READY),
      .FIFO_READ  (FIFO_READ),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_DATA  (FIFO_DATA),
      .HB_PERIOD  (HB_PERIOD),
      .CLEAR      (CLEAR),
      .HB_OVERRUN (HB_OVERRUN),
      .WORD_CNT   (WORD_CNT)
   );

   // clock / cycle counter
   always #5 BUS_CLK = ~BUS_CLK;

   int cyc = 0;
   always @(posedge BUS_CLK) cyc <= cyc + 1;

   // scoreboard state
   logic [31:0] exp_q[$];
   int          pop_cyc_q[$];
   int          total = 0;
   int          bad = 0;
   int          acc_cnt = 0;
   int          src_left = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%08h want=%08h", name, got, want);
      end
   endtask

   task automatic monitor();
      logic [31:0] w;
      forever begin
         @(negedge BUS_CLK);
         if (BUS_RST && FIFO_READ && !FIFO_EMPTY) begin
            pop_cyc_q.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_word got=%08h want=none", FIFO_DATA);
            end else begin
               w = exp_q.pop_front();
               if (FIFO_DATA !== w) begin
                  bad++;
                  $display("FAIL stream_word got=%08h want=%08h", FIFO_DATA, w);
               end
            end
         end
      end
   endtask

   // driver tasks
   task automatic start_src(input logic [31:0] first, input int n);
      IN_DATA  = first;
      src_left = n;
      acc_cnt  = 0;
      IN_VALID = (n > 0);
   endtask

   task automatic step();
      logic acc_now;
      @(negedge BUS_CLK);
      acc_now = IN_VALID && IN_READY;
      if (acc_now) begin
         exp_q.push_back(IN_DATA);
         acc_cnt++;
      end
      @(posedge BUS_CLK);
      #1;
      if (acc_now) begin
         src_left--;
         if (src_left <= 0) IN_VALID = 1'b0;
         else IN_DATA = IN_DATA + 32'd1;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      BUS_RST   = 1'b0;
      IN_VALID  = 1'b0;
      FIFO_READ = 1'b0;
      HB_PERIOD = 16'd0;
      CLEAR     = 1'b0;
      exp_q.delete();
      pop_cyc_q.delete();
      repeat (3) @(posedge BUS_CLK);
      #1;
      BUS_RST = 1'b1;
      repeat (3) @(posedge BUS_CLK);
      #1;
   endtask

   initial begin
      fork
         monitor();
      join_none

      // reset state
      do_reset();
      check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
      check("rst_ready", 32'(IN_READY), 32'd1);
      check("rst_overrun", 32'(HB_OVERRUN), 32'd0);
      check("rst_wordcnt", WORD_CNT, 32'd0);

      // passthrough, no markers
      FIFO_READ = 1'b1;
      start_src(32'h1, 10);
      steps(40);
      check("pass_accepts", 32'(acc_cnt), 32'd10);
      check("pass_wordcnt", WORD_CNT, 32'd10);
      check("pass_drained", 32'(exp_q.size()), 32'd0);
      check("pass_pops", 32'(pop_cyc_q.size()), 32'd10);

      // full / backpressure
      do_reset();
      start_src(32'h100, 100);
      steps(6);
      check("full_accepts", 32'(acc_cnt), 32'd4);
      check("full_ready", 32'(IN_READY), 32'd0);
      check("full_wordcnt", WORD_CNT, 32'd4);
      FIFO_READ = 1'b1;
      step();
      FIFO_READ = 1'b0;
      check("full_pop_no_accept", 32'(acc_cnt), 32'd4);
      steps(4);
      check("full_one_more", 32'(acc_cnt), 32'd5);
      check("full_wordcnt2", WORD_CNT, 32'd5);
      IN_VALID  = 1'b0;
      FIFO_READ = 1'b1;
      steps(6);
      check("full_drained", 32'(exp_q.size()), 32'd0);
      check("full_empty", 32'(FIFO_EMPTY), 32'd1);

      // heartbeat markers every 5 clocks
      do_reset();
      FIFO_READ = 1'b1;
      HB_PERIOD = 16'd5;
      exp_q.push_back(32'h6000_0000);
      exp_q.push_back(32'h6000_0001);
      exp_q.push_back(32'h6000_0002);
      exp_q.push_back(32'h6000_0003);
      steps(23);
      HB_PERIOD = 16'd0;
      steps(5);
      check("hb_drained", 32'(exp_q.size()), 32'd0);
      check("hb_count", 32'(pop_cyc_q.size()), 32'd4);
      for (int i = 1; i < 4 && i < pop_cyc_q.size(); i++)
         check("hb_spacing", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'd5);
      check("hb_wordcnt", WORD_CNT, 32'd0);

      // overrun while full, single marker after drain, then CLEAR
      do_reset();
      start_src(32'h200, 4);
      steps(5);
      check("ovr_fill", 32'(acc_cnt), 32'd4);
      HB_PERIOD = 16'd2;
      steps(6);
      check("ovr_flag", 32'(HB_OVERRUN), 32'd1);
      check("ovr_ready", 32'(IN_READY), 32'd0);
      HB_PERIOD = 16'd0;
      FIFO_READ = 1'b1;
      exp_q.push_back(32'h6000_0000);
      steps(10);
      check("ovr_drained", 32'(exp_q.size()), 32'd0);
      check("ovr_pops", 32'(pop_cyc_q.size()), 32'd5);
      check("ovr_sticky", 32'(HB_OVERRUN), 32'd1);
      CLEAR = 1'b1;
      step();
      CLEAR = 1'b0;
      check("ovr_clear", 32'(HB_OVERRUN), 32'd0);
      check("clear_wordcnt", WORD_CNT, 32'd0);

      // marker has priority over pending data
      do_reset();
      FIFO_READ = 1'b1;
      HB_PERIOD = 16'd3;
      steps(3);
      HB_PERIOD = 16'd0;
      exp_q.push_back(32'h6000_0000);
      start_src(32'h300, 1);
      check("prio_ready_low", 32'(IN_READY), 32'd0);
      step();
      check("prio_no_accept", 32'(acc_cnt), 32'd0);
      check("prio_ready_high", 32'(IN_READY), 32'd1);
      step();
      check("prio_accept", 32'(acc_cnt), 32'd1);
      steps(4);
      check("prio_drained", 32'(exp_q.size()), 32'd0);
      check("prio_wordcnt", WORD_CNT, 32'd1);

      // reset mid-stream discards buffered words, SEQ restarts
      do_reset();
      start_src(32'h400, 3);
      steps(4);
      check("mid_wordcnt", WORD_CNT, 32'd3);
      check("mid_not_empty", 32'(FIFO_EMPTY), 32'd0);
      BUS_RST = 1'b0;
      #1;
      check("mid_rst_empty", 32'(FIFO_EMPTY), 32'd1);
      check("mid_rst_wordcnt", WORD_CNT, 32'd0);
      exp_q.delete();
      @(posedge BUS_CLK);
      #1;
      BUS_RST = 1'b1;
      repeat (3) @(posedge BUS_CLK);
      #1;
      check("mid_post_empty", 32'(FIFO_EMPTY), 32'd1);
      check("mid_post_ready", 32'(IN_READY), 32'd1);
      FIFO_READ = 1'b1;
      HB_PERIOD = 16'd2;
      exp_q.push_back(32'h6000_0000);
      steps(3);
      HB_PERIOD = 16'd0;
      steps(3);
      check("mid_marker_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tpx3_stream_marker.md
TPX3_STREAM_MARKER -- requirements
Module: tpx3_stream_marker

Interface
REQ-001 SHALL have parameter DEPTH, default 4: internal buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter IDENTIFIER, default 4'b0110: marker word tag in bits [31:28].
REQ-003 SHALL have port BUS_CLK  input  1: single clock for all logic.
REQ-004 SHALL have port BUS_RST  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port IN_VALID  input  1: upstream (arbiter WRITE_OUT) word valid.
REQ-006 SHALL have port IN_DATA  input  32: upstream data word.
REQ-007 SHALL have port IN_READY  output  1: block accepts IN_DATA this cycle (drives arbiter READY_OUT).
REQ-008 SHALL have port FIFO_READ  input  1: downstream pop strobe (bram_fifo FIFO_READ_NEXT_OUT).
REQ-009 SHALL have port FIFO_EMPTY  output  1: no word available downstream.
REQ-010 SHALL have port FIFO_DATA  output  32: head word, first-word-fall-through.
REQ-011 SHALL have port HB_PERIOD  input  16: heartbeat period in clocks; 0 disables markers.
REQ-012 SHALL have port CLEAR  input  1: synchronous clear of HB_OVERRUN and WORD_CNT.
REQ-013 SHALL have port HB_OVERRUN  output  1: sticky, a heartbeat expired while a marker was still pending.
REQ-014 SHALL have port WORD_CNT  output  32: count of data words (markers excluded) accepted from upstream.

Function
REQ-015 SHALL buffer words in a DEPTH-entry circular FIFO with count; full = count==DEPTH, empty = count==0.
REQ-016 SHALL drive FIFO_EMPTY = empty and FIFO_DATA = head entry combinationally from registered state.
REQ-017 SHALL pop the head on FIFO_READ & !FIFO_EMPTY; FIFO_READ while empty is ignored (no state change).
REQ-018 SHALL make a word accepted in cycle N visible (FIFO_EMPTY=0 if previously empty) in cycle N+1.
REQ-019 SHALL maintain a 16-bit heartbeat counter HB_CNT: held at 0 while HB_PERIOD==0; otherwise increments each clock, and when HB_CNT==HB_PERIOD-1 wraps to 0 and raises an expiry.
REQ-020 SHALL set flag PENDING on expiry; if PENDING already 1 at expiry, SHALL set HB_OVERRUN and keep one pending marker.
REQ-021 SHALL write marker word {IDENTIFIER, SEQ[27:0]} when PENDING & !full, clear PENDING, and increment 28-bit SEQ (wraps 0x FFFFFFF -> 0).
REQ-022 SHALL drive IN_READY = !full & !PENDING (combinational); markers have priority over data.
REQ-023 SHALL write IN_DATA unchanged when IN_VALID & IN_READY, and increment WORD_CNT (wraps at 2^32).
REQ-024 SHALL allow simultaneous write and pop in one cycle, count unchanged; when full, a same-cycle pop SHALL NOT enable a write that cycle.
REQ-025 SHALL, on expiry in the same cycle a marker is written, re-set PENDING (no overrun flagged).
REQ-026 SHALL apply CLEAR after that cycle's increment, i.e. CLEAR has priority: WORD_CNT=0, HB_OVERRUN=0 next cycle.
REQ-027 SHALL restart HB_CNT from 0 whenever HB_PERIOD is written to 0; a change between nonzero values takes effect at the next compare.
REQ-028 SHALL never drop or duplicate a data word; upstream stalls via IN_READY only.

Reset
REQ-029 SHALL, while BUS_RST low, asynchronously clear pointers, count, HB_CNT, SEQ, PENDING, HB_OVERRUN, WORD_CNT.
REQ-030 SHALL output after reset: FIFO_EMPTY=1, IN_READY=1, HB_OVERRUN=0, WORD_CNT=0, FIFO_DATA don't-care.
REQ-031 SHALL discard buffered words on reset assertion mid-operation; first marker after reset carries SEQ=0.
REQ-032 SHALL release reset synchronously to BUS_CLK (deassertion sampled by a 2-flop synchronizer inside the block).

Verification
REQ-033 SHALL test passthrough: HB_PERIOD=0, 10 words 0x1..0xA, FIFO_READ held 1 -> same 10 words in order, WORD_CNT=10, no markers.
REQ-034 SHALL test full/backpressure: DEPTH=4, FIFO_READ=0, IN_VALID=1 for 6 cycles -> IN_READY=0 after 4 accepts, WORD_CNT=4; one pop -> exactly one more accept.
REQ-035 SHALL test heartbeat: HB_PERIOD=5, no data, FIFO_READ=1 -> markers 0x60000000, 0x60000001, ... one per 5 clocks.
REQ-036 SHALL test overrun: HB_PERIOD=2, FIFO full, FIFO_READ=0 for 6 clocks -> HB_OVERRUN=1; after draining, exactly one marker; CLEAR -> HB_OVERRUN=0.
REQ-037 SHALL test priority: PENDING=1 and IN_VALID=1, not full -> marker written first, IN_READY=0 that cycle, data accepted next cycle.
REQ-038 SHALL test reset mid-stream: 3 words buffered, BUS_RST low 1 cycle -> FIFO_EMPTY=1, WORD_CNT=0, next marker SEQ=0.
